// File: rtl/reg_bank_write_decoder.sv
// reg_bank_write_decoder: 16 x WIDTH register bank written through two
// one-hot decoded write ports, with a dedicated PC load path into R15.
// Ports:
//   clk, reset_n            - rising-edge clock, synchronous active-low reset
//   we_a/wa_a/wd_a          - write port A (primary writeback, wins collisions)
//   we_b/wa_b/wd_b          - write port B (base-register writeback)
//   pc_ld/pc_next           - load R15 when no port writes R15 this cycle
//   R0..R15                 - registered register contents
//   dec_a/dec_b             - combinational one-hot decode of each write port
module reg_bank_write_decoder #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] PC_RESET = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we_a,
  input  logic [3:0]       wa_a,
  input  logic [WIDTH-1:0] wd_a,
  input  logic             we_b,
  input  logic [3:0]       wa_b,
  input  logic [WIDTH-1:0] wd_b,
  input  logic             pc_ld,
  input  logic [WIDTH-1:0] pc_next,
  output logic [WIDTH-1:0] R0,
  output logic [WIDTH-1:0] R1,
  output logic [WIDTH-1:0] R2,
  output logic [WIDTH-1:0] R3,
  output logic [WIDTH-1:0] R4,
  output logic [WIDTH-1:0] R5,
  output logic [WIDTH-1:0] R6,
  output logic [WIDTH-1:0] R7,
  output logic [WIDTH-1:0] R8,
  output logic [WIDTH-1:0] R9,
  output logic [WIDTH-1:0] R10,
  output logic [WIDTH-1:0] R11,
  output logic [WIDTH-1:0] R12,
  output logic [WIDTH-1:0] R13,
  output logic [WIDTH-1:0] R14,
  output logic [WIDTH-1:0] R15,
  output logic [15:0]      dec_a,
  output logic [15:0]      dec_b
);

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned PC_IDX   = 15;

  logic [WIDTH-1:0] regs [NUM_REGS];

  // One-hot write decoders; forced to zero when the port is idle.
  always_comb begin
    dec_a = 16'h0000;
    dec_b = 16'h0000;
    if (we_a) dec_a = 16'(1) << wa_a;
    if (we_b) dec_b = 16'(1) << wa_b;
  end

  // Register bank: port A beats port B; on R15 both beat pc_ld.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(PC_IDX); i++) regs[i] <= '0;
      regs[PC_IDX] <= PC_RESET;
    end else begin
      for (int i = 0; i < int'(PC_IDX); i++) begin
        if (dec_a[i])      regs[i] <= wd_a;
        else if (dec_b[i]) regs[i] <= wd_b;
      end
      if (dec_a[PC_IDX])      regs[PC_IDX] <= wd_a;
      else if (dec_b[PC_IDX]) regs[PC_IDX] <= wd_b;
      else if (pc_ld)         regs[PC_IDX] <= pc_next;
    end
  end

  // Parallel register view for the operand read muxes.
  assign R0  = regs[0];
  assign R1  = regs[1];
  assign R2  = regs[2];
  assign R3  = regs[3];
  assign R4  = regs[4];
  assign R5  = regs[5];
  assign R6  = regs[6];
  assign R7  = regs[7];
  assign R8  = regs[8];
  assign R9  = regs[9];
  assign R10 = regs[10];
  assign R11 = regs[11];
  assign R12 = regs[12];
  assign R13 = regs[13];
  assign R14 = regs[14];
  assign R15 = regs[15];

endmodule

// File: tb/tb_reg_bank_write_decoder.sv
// Self-checking bench for reg_bank_write_decoder: a reference model predicts
// the full register file per cycle, expectations are queued when stimulus is
// driven and popped/compared after the clock edge.
module tb_reg_bank_write_decoder;

  localparam int unsigned    W        = 32;
  localparam logic [W-1:0]   PC_RST_V = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         we_a, we_b, pc_ld;
  logic [3:0]   wa_a, wa_b;
  logic [W-1:0] wd_a, wd_b, pc_next;
  logic [W-1:0] r [16];
  logic [15:0]  dec_a, dec_b;

  always #5 clk = ~clk;

  reg_bank_write_decoder #(.WIDTH(W), .PC_RESET(PC_RST_V)) dut (
    .clk(clk), .reset_n(reset_n),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a),
    .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
    .pc_ld(pc_ld), .pc_next(pc_next),
    .R0(r[0]), .R1(r[1]), .R2(r[2]), .R3(r[3]),
    .R4(r[4]), .R5(r[5]), .R6(r[6]), .R7(r[7]),
    .R8(r[8]), .R9(r[9]), .R10(r[10]), .R11(r[11]),
    .R12(r[12]), .R13(r[13]), .R14(r[14]), .R15(r[15]),
    .dec_a(dec_a), .dec_b(dec_b)
  );

  typedef struct {
    int           idx;
    logic [W-1:0] val;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] model [16];
  int           checks = 0;
  int           errors = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected one-hot, built bit by bit.
  function automatic logic [15:0] onehot(input logic we, input logic [3:0] wa);
    logic [15:0] v;
    v = '0;
    for (int k = 0; k < 16; k++) v[k] = we && (wa == 4'(k));
    return v;
  endfunction

  // Drive one cycle, check decoders, predict, clock, then drain the scoreboard.
  task automatic cycle(input logic rst_i,
                       input logic we_a_i, input logic [3:0] wa_a_i, input logic [W-1:0] wd_a_i,
                       input logic we_b_i, input logic [3:0] wa_b_i, input logic [W-1:0] wd_b_i,
                       input logic pc_ld_i, input logic [W-1:0] pc_next_i);
    exp_t e;
    reset_n = rst_i;
    we_a = we_a_i; wa_a = wa_a_i; wd_a = wd_a_i;
    we_b = we_b_i; wa_b = wa_b_i; wd_b = wd_b_i;
    pc_ld = pc_ld_i; pc_next = pc_next_i;
    #1;
    check("dec_a", W'(dec_a), W'(onehot(we_a_i, wa_a_i)));
    check("dec_b", W'(dec_b), W'(onehot(we_b_i, wa_b_i)));
    // Lowest priority applied first so higher-priority sources overwrite it.
    if (!rst_i) begin
      for (int i = 0; i < 15; i++) model[i] = '0;
      model[15] = PC_RST_V;
    end else begin
      if (pc_ld_i) model[15] = pc_next_i;
      if (we_b_i)  model[wa_b_i] = wd_b_i;
      if (we_a_i)  model[wa_a_i] = wd_a_i;
    end
    for (int i = 0; i < 16; i++) begin
      e.idx = i;
      e.val = model[i];
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("R%0d", e.idx), r[e.idx], e.val);
    end
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b0, '0);
  endtask

  initial begin
    // Reset overrides a concurrent write and pc_ld.
    cycle(1'b0, 1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0, '0, 1'b1, 32'h0000_0040);
    check("reset_R3_not_written", r[3], 32'h0);
    check("reset_R15", r[15], PC_RST_V);
    cycle(1'b1, 1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0, 4'd0, '0, 1'b0, '0);
    check("R3_after_release", r[3], 32'hDEAD_BEEF);

    // Port A sweep over R0..R14.
    for (int n = 0; n < 15; n++)
      cycle(1'b1, 1'b1, 4'(n), W'(n) * 32'h1111_1111, 1'b0, 4'd0, '0, 1'b0, '0);
    check("sweep_R14", r[14], 32'hEEEE_EEEE);

    // Dual write to distinct registers.
    cycle(1'b1, 1'b1, 4'd2, 32'hA, 1'b1, 4'd5, 32'hB, 1'b0, '0);
    check("dual_R2", r[2], 32'hA);
    check("dual_R5", r[5], 32'hB);

    // Collision: port A wins.
    cycle(1'b1, 1'b1, 4'd7, 32'h1234_5678, 1'b1, 4'd7, 32'h8765_4321, 1'b0, '0);
    check("collide_R7", r[7], 32'h1234_5678);

    // PC path priority.
    cycle(1'b1, 1'b0, 4'd0, '0, 1'b0, 4'd0, '0, 1'b1, 32'h0000_0004);
    check("pc_ld_R15", r[15], 32'h4);
    cycle(1'b1, 1'b1, 4'd15, 32'h0000_0100, 1'b0, 4'd0, '0, 1'b1, 32'h0000_0008);
    check("pc_portA_R15", r[15], 32'h100);
    cycle(1'b1, 1'b0, 4'd0, '0, 1'b1, 4'd15, 32'h0000_0200, 1'b1, 32'h0000_000C);
    check("pc_portB_R15", r[15], 32'h200);
    cycle(1'b1, 1'b1, 4'd15, 32'h0000_0300, 1'b1, 4'd15, 32'h0000_0400, 1'b1, 32'h0000_0010);
    check("pc_A_over_B_R15", r[15], 32'h300);

    // Disabled write holds R9 over three edges.
    for (int k = 0; k < 3; k++)
      cycle(1'b1, 1'b0, 4'd9, 32'hFFFF_FFFF, 1'b0, 4'd9, 32'hFFFF_FFFF, 1'b0, '0);
    check("disabled_R9", r[9], 32'h9999_9999);

    // Randomised mix of writes and PC loads.
    for (int k = 0; k < 40; k++)
      cycle(1'b1, 1'($urandom), 4'($urandom), W'($urandom), 1'($urandom), 4'($urandom),
            W'($urandom), 1'($urandom), W'($urandom));

    // Mid-operation reset discards pending writes, then writes resume.
    cycle(1'b0, 1'b1, 4'd15, 32'h5555_5555, 1'b1, 4'd1, 32'h6666_6666, 1'b1, 32'h44);
    check("midreset_R1", r[1], 32'h0);
    check("midreset_R15", r[15], PC_RST_V);
    cycle(1'b1, 1'b0, 4'd0, '0, 1'b1, 4'd1, 32'h6666_6666, 1'b1, 32'h44);
    check("post_reset_R1", r[1], 32'h6666_6666);
    check("post_reset_R15", r[15], 32'h44);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_write_decoder.md
# reg_bank_write_decoder

Write-side companion to the 16:1 register read multiplexers: a 16 x 32-bit register bank whose writes are steered by 4-to-16 one-hot decoders. It has two register-write ports and a dedicated PC (R15) load path. All 16 registers are exposed in parallel so the existing 16x1 read muxes can select operands from them. It sits in the datapath between writeback (ALU result, load data, base-register writeback) and the operand read muxes.

## Interface
Parameters:
- WIDTH, 32, register data width
- PC_RESET, 32'h0000_0000, value loaded into R15 on reset

Ports:
- clk  input  1  rising-edge clock, sole clock of the block
- reset_n  input  1  synchronous, active-low reset
- we_a  input  1  write enable, port A (primary writeback)
- wa_a  input  4  destination register number, port A
- wd_a  input  WIDTH  write data, port A
- we_b  input  1  write enable, port B (base-register writeback)
- wa_b  input  4  destination register number, port B
- wd_b  input  WIDTH  write data, port B
- pc_ld  input  1  load R15 from pc_next
- pc_next  input  WIDTH  next program counter value (PC+4 or branch target from upstream)
- R0 … R15  output  WIDTH each  current register contents (registered)
- dec_a  output  16  one-hot decode of port A this cycle (all zero when we_a=0), combinational
- dec_b  output  16  one-hot decode of port B this cycle (all zero when we_b=0), combinational

## Operation
- The decoder converts wa_x to a one-hot bit wa_x when we_x=1, else 16'h0000. No X is allowed on dec_x when we_x=0.
- Effective per-register enable for Rn (n≠15) is dec_a[n] | dec_b[n].
  - Data is wd_a if dec_a[n], else wd_b.
  - Same-register collision: port A wins; port B data is dropped.
- R15 priority, highest first: reset → port A write → port B write → pc_ld → hold.
  - A register write to R15 is a branch-by-write and overrides pc_ld in the same cycle.
- Registers with no active enable hold their value.
- Reset (reset_n=0 at a rising edge):
  - R0–R14 = 0.
  - R15 = PC_RESET.
  - Overrides every write and pc_ld in that cycle.
- Writes are pure stores: no arithmetic in the block, and data is taken as-is at WIDTH bits.
- The block never modifies wa_x/wd_x. Out-of-range addresses cannot occur (4-bit field covers 0–15).

## Timing
- All state updates on the rising edge of clk; no latches.
- Write latency 1 cycle: data presented at edge k is visible on Rn after edge k. There is no internal bypass, so a read of Rn in the same cycle as its write returns the old value. Forwarding is upstream's job.
- dec_a/dec_b are combinational from we_x/wa_x with zero latency.
- Reset mid-operation: an asserted reset_n=0 at an edge discards every pending write that cycle. The first write accepted is at the first edge with reset_n=1.
- Outputs after reset: R0–R14 = 0, R15 = PC_RESET, from the edge where reset is sampled low. Before the first clock edge, outputs are undefined.
- Simultaneous events are resolved in one cycle per the priority above; no stall or handshake.

## Test plan
- Reset: drive we_a=1, wa_a=3, wd_a=32'hDEAD_BEEF, pc_ld=1 with reset_n=0 for 1 edge → R0–R14=0, R15=PC_RESET, R3≠DEADBEEF. Release reset, repeat the write → R3=32'hDEAD_BEEF one edge later.
- Sweep: for n=0..14 write wd_a=n*32'h1111_1111 on port A, one per cycle → after each edge only Rn changes; dec_a = 1<<n during the cycle; all other registers hold.
- Dual write, distinct targets: we_a=1, wa_a=2, wd_a=32'hA; we_b=1, wa_b=5, wd_b=32'hB → R2=32'hA and R5=32'hB after the same edge.
- Collision: both ports target R7, wd_a=32'h1234_5678, wd_b=32'h8765_4321 → R7=32'h1234_5678.
- PC priority:
  - pc_ld=1, pc_next=32'h0000_0004, no writes → R15=4.
  - Next cycle: pc_ld=1, pc_next=8 with we_a=1, wa_a=15, wd_a=32'h0000_0100 → R15=32'h100.
  - Next cycle: we_b-only write to R15 with pc_ld=1 → port B value wins.
- Disabled write: we_a=0, we_b=0, wa_a=9, wd_a=32'hFFFF_FFFF → dec_a=16'h0000, R9 unchanged over 3 edges.
